// File: rtl/fir_cmplx_decim.sv
`timescale 1ns/1ps
`default_nettype none
// fir_cmplx_decim: complex FIR with true decimation, one tap per cycle on a shared complex MAC.
// Revision: 1.0
module fir_cmplx_decim #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 10,
  parameter int TAPS        = 20,
  parameter int DECIMATION  = 1,
  parameter int CMPLX_COEFF = 1,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] H_REAL = '0,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] H_IMAG = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  x_real_empty,
  input  logic                  x_imag_empty,
  input  logic [DATA_WIDTH-1:0] x_real_in,
  input  logic [DATA_WIDTH-1:0] x_imag_in,
  output logic                  x_real_rd_en,
  output logic                  x_imag_rd_en,
  input  logic                  y_real_full,
  input  logic                  y_imag_full,
  output logic [DATA_WIDTH-1:0] y_real_out,
  output logic [DATA_WIDTH-1:0] y_imag_out,
  output logic                  y_real_wr_en,
  output logic                  y_imag_wr_en
);

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(DECIMATION - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] shift_real [TAPS];
  logic signed [DATA_WIDTH-1:0] shift_imag [TAPS];
  logic [CNT_W-1:0]             sample_cnt;
  logic [TAP_W-1:0]             tap;
  logic signed [DATA_WIDTH-1:0] acc_r;
  logic signed [DATA_WIDTH-1:0] acc_i;
  logic [DATA_WIDTH-1:0]        y_r;
  logic [DATA_WIDTH-1:0]        y_i;

  logic                         pop;
  logic                         push;
  logic [TAP_W-1:0]             coef_idx;
  logic signed [DATA_WIDTH-1:0] xr, xi, hr, hi;
  logic signed [2*DATA_WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_WIDTH-1:0] acc_r_next;
  logic signed [DATA_WIDTH-1:0] acc_i_next;

  function automatic logic signed [DATA_WIDTH-1:0] dq(input logic signed [2*DATA_WIDTH-1:0] p);
    return DATA_WIDTH'(p >>> FRAC_BITS);
  endfunction

  // Handshakes are gated by rst_n so nothing is popped or pushed while reset is held.
  assign pop  = rst_n && (state == LOAD) && !x_real_empty && !x_imag_empty;
  assign push = rst_n && (state == OUT) && !y_real_full && !y_imag_full;

  assign x_real_rd_en = pop;
  assign x_imag_rd_en = pop;
  assign y_real_wr_en = push;
  assign y_imag_wr_en = push;
  assign y_real_out   = y_r;
  assign y_imag_out   = y_i;

  // Coefficients are stored time-reversed relative to the history index.
  assign coef_idx = LAST_TAP - tap;
  assign xr       = shift_real[tap];
  assign xi       = shift_imag[tap];
  assign hr       = H_REAL[coef_idx];

  if (CMPLX_COEFF != 0) begin : g_cmplx
    assign hi = H_IMAG[coef_idx];
  end else begin : g_real_only
    assign hi = '0;
  end

  assign p_rr = xr * hr;
  assign p_ii = xi * hi;
  assign p_ri = xr * hi;
  assign p_ir = xi * hr;

  assign acc_r_next = acc_r + dq(p_rr) - dq(p_ii);
  assign acc_i_next = acc_i + dq(p_ri) + dq(p_ir);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      sample_cnt <= '0;
      tap        <= '0;
      acc_r      <= '0;
      acc_i      <= '0;
      y_r        <= '0;
      y_i        <= '0;
      for (int i = 0; i < TAPS; i++) begin
        shift_real[i] <= '0;
        shift_imag[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (pop) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              shift_real[i] <= shift_real[i-1];
              shift_imag[i] <= shift_imag[i-1];
            end
            shift_real[0] <= x_real_in;
            shift_imag[0] <= x_imag_in;
            if (sample_cnt == LAST_SAMPLE) begin
              sample_cnt <= '0;
              acc_r      <= '0;
              acc_i      <= '0;
              tap        <= '0;
              state      <= MAC;
            end else begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
        end
        MAC: begin
          acc_r <= acc_r_next;
          acc_i <= acc_i_next;
          if (tap == LAST_TAP) begin
            y_r   <= acc_r_next;
            y_i   <= acc_i_next;
            state <= OUT;
          end else begin
            tap <= tap + TAP_W'(1);
          end
        end
        OUT: begin
          if (push) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fir_cmplx_decim.md
Name: fir_cmplx_decim

Overview:
- Parametrised complex FIR filter with true decimation by DECIMATION, for the channel-select and decimate stage of the FM demod chain, between the IQ input FIFOs and the demodulator FIFOs.
- Uses one time-shared complex MAC (4 real multiplies per cycle) and processes one tap per cycle.
- Dequantisation is an arithmetic right shift by FRAC_BITS.
- A real-only mode (CMPLX_COEFF=0) drops the imaginary-coefficient terms.

Parameters:
- DATA_WIDTH, 32, sample / coefficient / accumulator width, two's complement.
- FRAC_BITS, 10, fixed-point fraction bits; dequantise is a product arithmetic shift right by FRAC_BITS.
- TAPS, 20, filter length, 2..127.
- DECIMATION, 1, input samples consumed per output, 1..16.
- CMPLX_COEFF, 1, 1 = full complex coefficients, 0 = H_IMAG ignored (treated as zero).
- H_REAL, all zero, real coefficients, packed array [0:TAPS-1][DATA_WIDTH-1:0].
- H_IMAG, all zero, imaginary coefficients, same shape as H_REAL.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- x_real_empty  in  1  real input FIFO empty.
- x_imag_empty  in  1  imaginary input FIFO empty.
- x_real_in  in  DATA_WIDTH  real input sample (FIFO head).
- x_imag_in  in  DATA_WIDTH  imaginary input sample (FIFO head).
- x_real_rd_en  out  1  pop real input FIFO.
- x_imag_rd_en  out  1  pop imaginary input FIFO.
- y_real_full  in  1  real output FIFO full.
- y_imag_full  in  1  imaginary output FIFO full.
- y_real_out  out  DATA_WIDTH  filtered real output.
- y_imag_out  out  DATA_WIDTH  filtered imaginary output.
- y_real_wr_en  out  1  push real output FIFO.
- y_imag_wr_en  out  1  push imaginary output FIFO.

Behaviour:
- Reset and clocking
  - Single clock.
  - Reset is synchronous, active-low (rst_n sampled on rising clk).
  - Reset clears: state to LOAD, all history registers, sample counter, tap counter, both accumulators, both output data registers.
  - After reset, rd_en and wr_en are 0 and y_*_out are 0.
  - Reset mid-operation discards any partial sum; no write is issued for it.
- History
  - shift_real/shift_imag, TAPS entries; entry 0 is the newest sample.
  - Each pop shifts entries toward higher index and loads entry 0 from x_*_in.
  - The oldest entry is dropped.
- State LOAD
  - rd_en on both FIFOs is combinational: asserted only when !x_real_empty && !x_imag_empty.
  - The two FIFOs are always popped together; a one-side-empty condition stalls with no pop.
  - Each pop increments the sample counter.
  - On the DECIMATION-th pop: counter returns to 0, accumulators clear, tap index k=0, go to MAC.
- State MAC, one tap per cycle, k = 0..TAPS-1
  - xr = shift_real[k], xi = shift_imag[k].
  - hr = H_REAL[TAPS-1-k], hi = H_IMAG[TAPS-1-k] (coefficients are stored time-reversed).
  - Products are full 2*DATA_WIDTH signed.
  - dq(p) = (p >>> FRAC_BITS) truncated to DATA_WIDTH.
  - acc_r += dq(xr*hr) - dq(xi*hi).
  - acc_i += dq(xr*hi) + dq(xi*hr).
  - When CMPLX_COEFF=0 the hi terms are 0.
  - Accumulators are DATA_WIDTH and wrap modulo 2^DATA_WIDTH; no saturation.
  - After k=TAPS-1: latch acc into the y_*_out registers and go to OUT.
  - No FIFO activity during MAC.
- State OUT
  - wr_en on both FIFOs is combinational: asserted only when !y_real_full && !y_imag_full.
  - On that cycle, go to LOAD.
  - While either FIFO is full: hold, wr_en=0, outputs stable, no reads.
- Outputs
  - y_*_out are registered and hold the last result until the next latch.
  - They are valid whenever wr_en is high.
- Latency and throughput
  - First output write occurs TAPS+1 cycles after the cycle of the DECIMATION-th pop.
  - Peak throughput is one output per DECIMATION+TAPS+1 cycles.
- Ordering
  - Input pops and output writes never occur in the same cycle.
  - Exactly one output write per DECIMATION input pops.

Test Plan:
- Impulse: TAPS=4, DEC=1, FRAC=10, H_REAL={1024,2048,3072,4096}, H_IMAG=0; input (1024,0) then zeros -> y_real = 4096, 3072, 2048, 1024, 0, 0; y_imag all 0.
- Decimation: same filter, DEC=2, same impulse -> y_real = 3072, 1024, 0; 1 write per 2 pops; rd_en never coincides with wr_en.
- Complex multiply: TAPS=4, H_REAL=0, H_IMAG={0,0,0,1024}, input (0,1024) -> first output (-1024, 0). With CMPLX_COEFF=0 -> (0, 0).
- Rounding and wrap:
  - x_real=-1 raw, H_REAL[3]=1 raw -> y_real=-1 (floor).
  - Accumulation past 2^31-1 wraps negative.
- Backpressure and stall:
  - Hold y_real_full=1 for 5 cycles in OUT -> no wr_en, no rd_en, outputs stable; write fires the cycle full drops.
  - x_imag_empty=1 with x_real non-empty -> no pops.
- Reset: drive rst_n=0 for 1 cycle mid-MAC -> next cycle state LOAD, no write; a subsequent impulse yields a clean 4096, 3072, 2048, 1024 response with no residual history.
